// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl shared constants: bus polarity, widths,
// register map, control/status bits and FSM encoding.
package dma_ctrl_pkg;

  localparam int DMA_ADDR_W = 12;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_CNT_W  = 12;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam logic [1:0] DMA_CTRL = 2'd0;
  localparam logic [1:0] DMA_SRC  = 2'd1;
  localparam logic [1:0] DMA_DST  = 2'd2;
  localparam logic [1:0] DMA_CNT  = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_DONE_CLR = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;
  localparam int ST_IRQ_EN  = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB_R = 3'd1;
  localparam logic [2:0] S_RD_AS = 3'd2;
  localparam logic [2:0] S_RD_WT = 3'd3;
  localparam logic [2:0] S_WR_AS = 3'd4;
  localparam logic [2:0] S_WR_WT = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

endpackage

// File: rtl/dma_ctrl_if.sv
// dma_ctrl bus bundle: slave register window
// plus the bus master 2 port and the irq line.
interface dma_ctrl_if #(
  parameter int ADDR_W = dma_ctrl_pkg::DMA_ADDR_W,
  parameter int DATA_W = dma_ctrl_pkg::DMA_DATA_W
);
  logic              s_cs_;
  logic              s_as_;
  logic              s_rw;
  logic [1:0]        s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy_;
  logic              m_req_;
  logic              m_grnt_;
  logic [ADDR_W-1:0] m_addr;
  logic              m_as_;
  logic              m_rw;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rdy_;
  logic              irq;

  modport master (
    input  s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    input  m_grnt_, m_rd_data, m_rdy_,
    output s_rd_data, s_rdy_,
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    output irq
  );

  modport slave (
    output s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    output m_grnt_, m_rd_data, m_rdy_,
    input  s_rd_data, s_rdy_,
    input  m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input  irq
  );
endinterface

// File: rtl/dma_regs.sv
// dma_ctrl register file: slave decode, SRC/DST/CNT,
// status bits, pending abort and s_rdy_ generation.
module dma_regs import dma_ctrl_pkg::*; #(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  dma_ctrl_if.master        bus,
  input  logic              busy,
  input  logic              step,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [CNT_W-1:0]  cnt,
  output logic              go,
  output logic              fin
);

  logic acc, wr, ctrl_wr, start_ok, last, pend;
  logic done, aborted, irq_en, abort_q;
  logic [DATA_W-1:0] status, rd_mux;
  logic unused_wd;

  assign acc = (bus.s_cs_ == ENABLE_)
            && (bus.s_as_ == ENABLE_);
  assign wr = acc && (bus.s_rw == WRITE);
  assign ctrl_wr = wr && (bus.s_addr == DMA_CTRL);
  assign start_ok = ctrl_wr && !busy
                 && bus.s_wr_data[CTRL_START];
  assign go = start_ok && (cnt != '0);
  assign last = (cnt == CNT_W'(1));
  assign pend = abort_q
             || (ctrl_wr && bus.s_wr_data[CTRL_ABORT]);
  assign fin = step && (last || pend);
  assign bus.irq = done & irq_en;
  assign unused_wd = ^bus.s_wr_data;

  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_ABORTED] = aborted;
    status[ST_IRQ_EN] = irq_en;
    rd_mux = status;
    case (bus.s_addr)
      DMA_SRC: rd_mux = DATA_W'(src);
      DMA_DST: rd_mux = DATA_W'(dst);
      DMA_CNT: rd_mux = DATA_W'(cnt);
      default: rd_mux = status;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.s_rdy_    <= DISABLE_;
      bus.s_rd_data <= '0;
      src     <= '0;
      dst     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      irq_en  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      bus.s_rdy_ <= acc ? ENABLE_ : DISABLE_;
      bus.s_rd_data <= (acc && bus.s_rw == READ)
                     ? rd_mux : '0;
      if (ctrl_wr)
        irq_en <= bus.s_wr_data[CTRL_IRQ_EN];
      if (wr && !busy && bus.s_addr == DMA_SRC)
        src <= bus.s_wr_data[ADDR_W-1:0];
      else if (step)
        src <= src + ADDR_W'(1);
      if (wr && !busy && bus.s_addr == DMA_DST)
        dst <= bus.s_wr_data[ADDR_W-1:0];
      else if (step)
        dst <= dst + ADDR_W'(1);
      if (wr && !busy && bus.s_addr == DMA_CNT)
        cnt <= bus.s_wr_data[CNT_W-1:0];
      else if (step && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // completion beats a simultaneous done_clr
      if (start_ok)
        done <= (cnt == '0);
      else if (step && last)
        done <= 1'b1;
      else if (ctrl_wr && bus.s_wr_data[CTRL_DONE_CLR])
        done <= 1'b0;
      if (start_ok)
        aborted <= 1'b0;
      else if (fin && !last)
        aborted <= 1'b1;
      if (start_ok || fin)
        abort_q <= 1'b0;
      else if (ctrl_wr && busy && bus.s_wr_data[CTRL_ABORT])
        abort_q <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel word-copy DMA on bus master 2,
// read/write alternating FSM with register window on slave 5.
module dma_ctrl import dma_ctrl_pkg::*; #(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int CNT_W  = DMA_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  dma_ctrl_if.master bus
);

  logic [2:0] state, state_nx;
  logic [DATA_W-1:0] word_buf;
  logic [ADDR_W-1:0] src, dst;
  logic [CNT_W-1:0]  cnt;
  logic busy, step, go, fin, rdy, rd_as, wr_as;

  assign busy = (state != S_IDLE);
  assign rdy = (bus.m_rdy_ == ENABLE_);
  assign step = (state == S_WR_WT) && rdy;
  assign rd_as = (state == S_RD_AS);
  assign wr_as = (state == S_WR_AS);

  dma_regs #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_regs (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy),
    .step (step),
    .src  (src),
    .dst  (dst),
    .cnt  (cnt),
    .go   (go),
    .fin  (fin)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = S_ARB_R;
      S_ARB_R: if (bus.m_grnt_ == ENABLE_)
                 state_nx = S_RD_AS;
      S_RD_AS: state_nx = S_RD_WT;
      S_RD_WT: if (rdy) state_nx = S_WR_AS;
      S_WR_AS: state_nx = S_WR_WT;
      S_WR_WT: if (rdy)
                 state_nx = fin ? S_IDLE : S_GAP;
      S_GAP:   state_nx = S_ARB_R;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      word_buf <= '0;
    end else begin
      state <= state_nx;
      if (state == S_RD_WT && rdy)
        word_buf <= bus.m_rd_data;
    end
  end

  // GAP drops the request for a cycle so other masters can win
  assign bus.m_req_ = (state == S_IDLE || state == S_GAP)
                    ? DISABLE_ : ENABLE_;
  assign bus.m_as_ = (rd_as || wr_as) ? ENABLE_ : DISABLE_;
  assign bus.m_rw = wr_as ? WRITE : READ;
  assign bus.m_addr = rd_as ? src
                    : wr_as ? dst : '0;
  assign bus.m_wr_data = wr_as ? word_buf : '0;

endmodule

// File: tb/tb_dma_ctrl.sv
// dma_ctrl bench: memory/arbiter model on the master port,
// copy scoreboard, register-level checks of status and counters.
module tb_dma_ctrl;
  import dma_ctrl_pkg::*;

  typedef struct packed {
    logic [11:0] ra;
    logic [11:0] wa;
    logic [31:0] d;
  } xfer_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_ctrl_if bus ();

  dma_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  xfer_t sb[$];
  logic [31:0] mem [4096];
  int gnt_dly = 0;
  int rdy_dly = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int req_cnt = 0;
  int as_viol = 0;
  int gnt_viol = 0;
  int gcnt = 0;
  logic as_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // memory slave: answers each strobe after rdy_dly waits
  initial begin
    logic [11:0] a;
    logic rw;
    xfer_t x;
    bus.m_rdy_ = 1'b1;
    bus.m_rd_data = '0;
    forever begin
      @(negedge clk);
      bus.m_rdy_ = 1'b1;
      bus.m_rd_data = '0;
      if (bus.m_as_ == ENABLE_ && !reset) begin
        a = bus.m_addr;
        rw = bus.m_rw;
        if (rw == READ) begin
          rd_cnt++;
          if (sb.size() == 0)
            chk("rd_unexpected", 32'(a), 32'hFFFF_FFFF);
          else
            chk("rd_addr", 32'(a), 32'(sb[0].ra));
        end else begin
          wr_cnt++;
          mem[a] = bus.m_wr_data;
          if (sb.size() == 0)
            chk("wr_unexpected", 32'(a), 32'hFFFF_FFFF);
          else begin
            x = sb.pop_front();
            chk("wr_addr", 32'(a), 32'(x.wa));
            chk("wr_data", bus.m_wr_data, x.d);
          end
        end
        repeat (1 + rdy_dly) @(negedge clk);
        bus.m_rdy_ = 1'b0;
        if (rw == READ) bus.m_rd_data = mem[a];
      end
    end
  end

  initial begin
    bus.m_grnt_ = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.m_req_ == ENABLE_) begin
        if (gcnt >= gnt_dly) bus.m_grnt_ = 1'b0;
        else gcnt++;
      end else begin
        gcnt = 0;
        bus.m_grnt_ = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_as_ == ENABLE_) begin
        if (as_prev) as_viol++;
        if (bus.m_grnt_ != ENABLE_) gnt_viol++;
      end
      as_prev = (bus.m_as_ == ENABLE_);
      if (bus.m_req_ == ENABLE_) req_cnt++;
    end
  end

  task automatic reg_acc(input logic rw,
                         input logic [1:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] rd);
    @(negedge clk);
    bus.s_cs_ = 1'b0;
    bus.s_as_ = 1'b0;
    bus.s_rw = rw;
    bus.s_addr = a;
    bus.s_wr_data = wd;
    @(negedge clk);
    chk("s_rdy", 32'(bus.s_rdy_), 32'(ENABLE_));
    rd = bus.s_rd_data;
    bus.s_cs_ = 1'b1;
    bus.s_as_ = 1'b1;
    bus.s_wr_data = '0;
  endtask

  task automatic reg_wr(input logic [1:0] a,
                        input logic [31:0] wd);
    logic [31:0] d;
    reg_acc(WRITE, a, wd, d);
  endtask

  task automatic reg_rd(input logic [1:0] a,
                        output logic [31:0] d);
    reg_acc(READ, a, 32'h0, d);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    reg_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic push_xfer(input logic [11:0] s,
                           input logic [11:0] d,
                           input int n);
    for (int k = 0; k < n; k++)
      sb.push_back(xfer_t'{ra: s + 12'(k),
                           wa: d + 12'(k),
                           d: mem[s + 12'(k)]});
  endtask

  task automatic setup_xfer(input logic [31:0] s,
                            input logic [31:0] d,
                            input logic [31:0] c,
                            input logic [31:0] ctl);
    reg_wr(DMA_SRC, s);
    reg_wr(DMA_DST, d);
    reg_wr(DMA_CNT, c);
    reg_wr(DMA_CTRL, ctl);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n;
    n = 0;
    st = 32'h1;
    while (st[0] && n < 400) begin
      reg_rd(DMA_CTRL, st);
      n++;
    end
    chk("busy_timeout", 32'(st[0]), 32'h0);
  endtask

  task automatic wait_cnt(input int which, input int lim);
    int n;
    n = 0;
    while (((which == 0) ? rd_cnt : wr_cnt) < lim
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_timeout", 32'(n < 300), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    bus.s_cs_ = 1'b1;
    bus.s_as_ = 1'b1;
    bus.s_rw = READ;
    bus.s_addr = 2'd0;
    bus.s_wr_data = '0;
    for (int i = 0; i < 4096; i++)
      mem[i] = 32'hA500_0000 + i * 32'h0001_0003;
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(bus.m_req_), 32'h1);
    chk("rst_m_as", 32'(bus.m_as_), 32'h1);
    chk("rst_m_rw", 32'(bus.m_rw), 32'(READ));
    chk("rst_m_addr", 32'(bus.m_addr), 32'h0);
    chk("rst_s_rdy", 32'(bus.s_rdy_), 32'h1);
    chk("rst_s_rdata", bus.s_rd_data, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    reset = 1'b0;
    rd_chk("rst_status", DMA_CTRL, 32'h0);
    rd_chk("rst_cnt", DMA_CNT, 32'h0);

    // basic 3-word copy, zero waits
    push_xfer(12'h100, 12'h200, 3);
    setup_xfer(32'h100, 32'h200, 32'd3, 32'h3);
    wait_idle();
    chk("t1_irq", 32'(bus.irq), 32'h1);
    rd_chk("t1_status", DMA_CTRL, 32'h0A);
    rd_chk("t1_src", DMA_SRC, 32'h103);
    rd_chk("t1_dst", DMA_DST, 32'h203);
    rd_chk("t1_cnt", DMA_CNT, 32'h0);
    chk("t1_sb_left", 32'(sb.size()), 32'h0);
    chk("t1_reads", 32'(rd_cnt), 32'd3);
    chk("t1_writes", 32'(wr_cnt), 32'd3);

    // slow grant and slow ready
    gnt_dly = 5;
    rdy_dly = 3;
    as_viol = 0;
    gnt_viol = 0;
    push_xfer(12'h100, 12'h300, 3);
    setup_xfer(32'h100, 32'h300, 32'd3, 32'h3);
    wait_idle();
    chk("t2_as_pulse", 32'(as_viol), 32'h0);
    chk("t2_as_no_grant", 32'(gnt_viol), 32'h0);
    rd_chk("t2_status", DMA_CTRL, 32'h0A);
    chk("t2_sb_left", 32'(sb.size()), 32'h0);

    // address wrap
    gnt_dly = 0;
    rdy_dly = 0;
    push_xfer(12'hFFF, 12'h7FE, 2);
    setup_xfer(32'hFFF, 32'h7FE, 32'd2, 32'h1);
    wait_idle();
    rd_chk("t3_src", DMA_SRC, 32'h001);
    rd_chk("t3_dst", DMA_DST, 32'h800);
    rd_chk("t3_status", DMA_CTRL, 32'h02);
    chk("t3_irq", 32'(bus.irq), 32'h0);
    chk("t3_sb_left", 32'(sb.size()), 32'h0);

    // abort during the second word's read wait
    rdy_dly = 3;
    rd_cnt = 0;
    wr_cnt = 0;
    push_xfer(12'h400, 12'h500, 2);
    setup_xfer(32'h400, 32'h500, 32'd10, 32'h1);
    wait_cnt(0, 2);
    reg_wr(DMA_CTRL, 32'h4);
    wait_idle();
    rd_chk("t4_status", DMA_CTRL, 32'h04);
    rd_chk("t4_cnt", DMA_CNT, 32'd8);
    chk("t4_irq", 32'(bus.irq), 32'h0);
    chk("t4_writes", 32'(wr_cnt), 32'd2);
    chk("t4_sb_left", 32'(sb.size()), 32'h0);

    // zero-length start, idle abort, done_clr
    rdy_dly = 0;
    reg_wr(DMA_CNT, 32'h0);
    c0 = req_cnt;
    reg_wr(DMA_CTRL, 32'h3);
    chk("t5_irq", 32'(bus.irq), 32'h1);
    rd_chk("t5_status", DMA_CTRL, 32'h0A);
    chk("t5_no_req", 32'(req_cnt), 32'(c0));
    reg_wr(DMA_CTRL, 32'h6);
    rd_chk("t5_idle_abort", DMA_CTRL, 32'h0A);
    reg_wr(DMA_CTRL, 32'hA);
    chk("t5_irq_clr", 32'(bus.irq), 32'h0);
    rd_chk("t5_status_clr", DMA_CTRL, 32'h08);

    // reset in the middle of a write wait
    rdy_dly = 3;
    wr_cnt = 0;
    push_xfer(12'h600, 12'h700, 3);
    setup_xfer(32'h600, 32'h700, 32'd3, 32'h3);
    wait_cnt(1, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_m_req", 32'(bus.m_req_), 32'h1);
    chk("t6_m_as", 32'(bus.m_as_), 32'h1);
    chk("t6_m_addr", 32'(bus.m_addr), 32'h0);
    chk("t6_m_wdata", bus.m_wr_data, 32'h0);
    chk("t6_s_rdy", 32'(bus.s_rdy_), 32'h1);
    chk("t6_irq", 32'(bus.irq), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (8) @(negedge clk);
    rd_chk("t6_status", DMA_CTRL, 32'h0);
    rd_chk("t6_cnt", DMA_CNT, 32'h0);
    rd_chk("t6_src", DMA_SRC, 32'h0);
    chk("t6_m_req_idle", 32'(bus.m_req_), 32'h1);
    chk("t6_writes", 32'(wr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Single-channel word-copy DMA engine occupying the unused bus master 2 slot, plus one bus slave window (slave 5) for its control registers.
- Software programs source, destination and word count through the slave port, then sets start.
- The engine alternately reads from the source and writes to the destination over the shared bus, arbitrating like the CPU masters.
- On completion it raises a level interrupt on cpu_irq bit 3.

Parameters:
- ADDR_W, 12, word address width; matches the bus WordAddrBus.
- DATA_W, 32, data width; matches the bus WordDataBus.
- CNT_W, 12, transfer-count register width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_cs_  in  1  slave chip select, active low
- s_as_  in  1  slave address strobe, active low
- s_rw  in  1  slave read/write, READ=1, WRITE=0
- s_addr  in  2  register select (bus s_addr[1:0])
- s_wr_data  in  DATA_W  slave write data
- s_rd_data  out  DATA_W  slave read data
- s_rdy_  out  1  slave ready, active low
- m_req_  out  1  bus request, active low
- m_grnt_  in  1  bus grant, active low
- m_addr  out  ADDR_W  master address
- m_as_  out  1  master address strobe, active low
- m_rw  out  1  master read/write
- m_wr_data  out  DATA_W  master write data
- m_rd_data  in  DATA_W  shared master read data
- m_rdy_  in  1  shared master ready, active low
- irq  out  1  completion interrupt, level, active high

Behaviour:
- Reset (asynchronous, active-high) drives:
  - m_req_=1, m_as_=1, m_rw=READ, m_addr=0, m_wr_data=0
  - s_rdy_=1, s_rd_data=0, irq=0
  - SRC=DST=CNT=0, all status bits 0, FSM=IDLE
- Reset mid-transfer abandons the transfer immediately, with no partial update.
- Registers, selected by s_addr:
  - 0 CTRL write: bit0 start, bit1 irq_en, bit2 abort, bit3 done_clr.
  - 0 STATUS read: bit0 busy, bit1 done, bit2 aborted, bit3 irq_en, other bits 0.
  - 1 SRC (ADDR_W), 2 DST (ADDR_W), 3 CNT (CNT_W); these read back the live values.
- Slave access:
  - When s_cs_=0 and s_as_=0, the access is registered.
  - s_rdy_=0 for exactly the following cycle; s_rd_data is valid in that cycle and 0 otherwise.
  - Writes take effect at the same edge as the registration.
- While busy, writes to SRC/DST/CNT and start are ignored; irq_en, abort and done_clr are still accepted.
- Start with CNT=0 sets done (and irq if enabled) with no bus activity.
- A valid start clears done and aborted.
- FSM:
  - IDLE: m_req_=1. On a valid start with CNT≠0 → ARB_R, busy=1.
  - ARB_R: m_req_=0. When m_grnt_=0 → RD_AS.
  - RD_AS: one cycle with m_as_=0, m_addr=SRC, m_rw=READ → RD_WT.
  - RD_WT: m_req_=0, m_as_=1. When m_rdy_=0, latch m_rd_data into BUF → WR_AS.
  - WR_AS: one cycle with m_as_=0, m_addr=DST, m_rw=WRITE, m_wr_data=BUF → WR_WT.
  - WR_WT: when m_rdy_=0:
    - SRC+=1 and DST+=1 (mod 2^ADDR_W), CNT-=1.
    - If CNT becomes 0, or an abort is pending → IDLE.
    - Otherwise → GAP.
  - GAP: m_req_=1 for one cycle to release the bus for fairness → ARB_R.
- Outside RD_AS/WR_AS, m_addr, m_wr_data = 0 and m_rw=READ.
- Completion: entering IDLE from WR_WT with CNT=0 sets done=1, busy=0. Done after a start with CNT=0 is handled in IDLE as above.
- Abort:
  - Latched as pending.
  - Honoured only at the word boundary, after the write completes; never mid bus cycle.
  - On honour: busy=0, aborted=1, done unchanged, CNT shows the remaining words.
  - An abort while IDLE is ignored.
- irq = done & irq_en.
  - done_clr or a new start clears done.
  - If done_clr and completion occur in the same cycle, completion wins.
- Address wrap: 0xFFF+1 → 0x000, silently. CNT never decrements below 0.
- Throughput: 6 cycles per word at zero wait states with immediate grant (ARB_R, RD_AS, RD_WT, WR_AS, WR_WT, GAP).

Decomposition:
- Shared package/define file holds:
  - bus polarity constants (ENABLE_=0, DISABLE_=1, READ=1, WRITE=0);
  - widths;
  - register offsets (DMA_CTRL=0, DMA_SRC=1, DMA_DST=2, DMA_CNT=3) and CTRL/STATUS bit indices;
  - FSM state encoding.
- One sub-module, dma_regs: slave decode, register file, s_rdy_ generation.
- The FSM and datapath stay in dma_ctrl.

Test Plan:
- Write SRC=0x100, DST=0x200, CNT=3, CTRL=0x3; memory model with 0 wait states, grant immediate → 3 read/write pairs to 0x100..0x102 → 0x200..0x202; data copied; irq=1 after the final write's m_rdy_; STATUS=0x0A.
- Same setup with the grant held off 5 cycles and rdy_ delayed 3 cycles per access → m_as_ stays a single-cycle pulse, m_req_ held low until grant, data correct.
- SRC=0xFFF, DST=0x7FE, CNT=2 → reads at 0xFFF then 0x000; final SRC=0x001, DST=0x800.
- CNT=10, write abort during the 2nd word's RD_WT → 2nd write completes, FSM → IDLE, STATUS=0x04 (irq_en=0), CNT=8, no irq.
- Start with CNT=0, irq_en=1 → no m_req_ activity, done=1, irq=1; then write done_clr → irq=0 next cycle.
- Assert reset during WR_WT → all outputs at reset values asynchronously; after release, STATUS=0, m_req_=1.
